// File: rtl/ws2812_strip_driver.sv
// Frame-level WS2812/SK6812 serialiser: pulls NUM_LEDS*BYTES_PER_LED bytes through a
// one-byte holding register, shifts them out MSB first, then drives the latch gap.
// Optional build macro WS2812_UNDERRUN_FILL_EN: send 0x00 on refill underrun instead of stalling.
module ws2812_strip_driver #(
  parameter int NUM_LEDS      = 8,
  parameter int BYTES_PER_LED = 3,
  parameter int TBIT          = 15,
  parameter int T0H           = 4,
  parameter int T1H           = 9,
  parameter int TLATCH        = 3600,
  localparam int IDX_W        = $clog2(NUM_LEDS * BYTES_PER_LED + 1)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             dout,
  output logic [IDX_W-1:0] byte_index,
  output logic             underrun
);

  localparam int CNT_W = $clog2(TBIT);
  localparam int LAT_W = $clog2(TLATCH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0] THI1     = CNT_W'(T1H);
  localparam logic [CNT_W-1:0] THI0     = CNT_W'(T0H);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TLATCH - 1);
  localparam logic [IDX_W-1:0] TOTAL_V  = IDX_W'(NUM_LEDS * BYTES_PER_LED);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BIT, S_LATCH} state_t;

  state_t           state_q, state_n;
  logic [7:0]       hold_q, hold_n;
  logic             hold_full_q, hold_full_n;
  logic [7:0]       shift_q, shift_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       bit_q, bit_n;
  logic [IDX_W-1:0] slot_q, slot_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [LAT_W-1:0] lat_q, lat_n;
  logic             under_q, under_n;
  logic             ready_q, ready_n;
  logic             dout_q, dout_n;
  logic             done_q, done_n;
  logic             xfer;

  // Handshake: a byte moves on a rising CLK edge where byte_ready && byte_valid are both
  // high; byte_valid seen while byte_ready is low is ignored and never stalls the line.
  always_comb begin
    state_n     = state_q;
    hold_n      = hold_q;
    hold_full_n = hold_full_q;
    shift_n     = shift_q;
    cnt_n       = cnt_q;
    bit_n       = bit_q;
    slot_n      = slot_q;
    idx_n       = idx_q;
    lat_n       = lat_q;
    under_n     = under_q;
    xfer        = ready_q && byte_valid;

    // ready_q implies an empty holding register, so a transfer never collides with a load
    if (xfer) begin
      hold_n      = byte_in;
      hold_full_n = 1'b1;
      idx_n       = idx_q + IDX_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n     = S_WAIT;
          idx_n       = '0;
          slot_n      = '0;
          hold_full_n = 1'b0;
          under_n     = 1'b0;
        end
      end
      S_WAIT: begin
        if (hold_full_q) begin
          shift_n     = hold_q;
          hold_full_n = 1'b0;
          slot_n      = slot_q + IDX_W'(1);
          cnt_n       = '0;
          bit_n       = '0;
          state_n     = S_BIT;
        end
      end
      S_BIT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_n = cnt_q + CNT_W'(1);
        end else begin
          cnt_n = '0;
          if (bit_q != 3'd7) begin
            bit_n   = bit_q + 3'd1;
            shift_n = {shift_q[6:0], 1'b0};
          end else if (slot_q == TOTAL_V) begin
            state_n = S_LATCH;
            lat_n   = '0;
          end else if (hold_full_q) begin
            shift_n     = hold_q;
            hold_full_n = 1'b0;
            slot_n      = slot_q + IDX_W'(1);
            bit_n       = '0;
          end else begin
`ifdef WS2812_UNDERRUN_FILL_EN
            shift_n = 8'h00;
            slot_n  = slot_q + IDX_W'(1);
            bit_n   = '0;
            under_n = 1'b1;
`else
            state_n = S_WAIT;
`endif
          end
        end
      end
      S_LATCH: begin
        if (lat_q != LAT_LAST) lat_n = lat_q + LAT_W'(1);
        else state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they change cleanly on the edge
    ready_n = (state_n == S_WAIT || state_n == S_BIT) && !hold_full_n && (idx_n != TOTAL_V);
    dout_n  = (state_n == S_BIT) && (cnt_n < (shift_n[7] ? THI1 : THI0));
    done_n  = (state_n == S_LATCH) && (lat_n == LAT_LAST);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      slot_q      <= '0;
      idx_q       <= '0;
      lat_q       <= '0;
      under_q     <= 1'b0;
      ready_q     <= 1'b0;
      dout_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      hold_q      <= hold_n;
      hold_full_q <= hold_full_n;
      shift_q     <= shift_n;
      cnt_q       <= cnt_n;
      bit_q       <= bit_n;
      slot_q      <= slot_n;
      idx_q       <= idx_n;
      lat_q       <= lat_n;
      under_q     <= under_n;
      ready_q     <= ready_n;
      dout_q      <= dout_n;
      done_q      <= done_n;
    end
  end

  assign byte_ready = ready_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign dout       = dout_q;
  assign byte_index = idx_q;
  assign underrun   = under_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Directed bench for ws2812_strip_driver: default-parameter instance plus a small RGBW
// instance; measures dout pulse widths/periods and frame timing against hand-derived values.
module tb_ws2812_strip_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       m_start, m_byte_valid, m_byte_ready, m_busy, m_frame_done, m_dout, m_underrun;
  logic [7:0] m_byte_in;
  logic [4:0] m_byte_index;
  logic       s_start, s_byte_valid, s_byte_ready, s_busy, s_frame_done, s_dout, s_underrun;
  logic [7:0] s_byte_in;
  logic [3:0] s_byte_index;

  ws2812_strip_driver dut_main (
    .CLK(clk), .rst(rst), .start(m_start), .byte_in(m_byte_in), .byte_valid(m_byte_valid),
    .byte_ready(m_byte_ready), .busy(m_busy), .frame_done(m_frame_done), .dout(m_dout),
    .byte_index(m_byte_index), .underrun(m_underrun)
  );

  ws2812_strip_driver #(.NUM_LEDS(2), .BYTES_PER_LED(4), .TLATCH(50)) dut_small (
    .CLK(clk), .rst(rst), .start(s_start), .byte_in(s_byte_in), .byte_valid(s_byte_valid),
    .byte_ready(s_byte_ready), .busy(s_busy), .frame_done(s_frame_done), .dout(s_dout),
    .byte_index(s_byte_index), .underrun(s_underrun)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         k;
  bit         sel;
  logic [7:0] src_q[$];
  logic [7:0] slot_bytes[$];
  logic [7:0] exp_q[$];
  int         start_k[$];
  int         src_ptr, gap_idx, gap_release, total_bytes;
  logic       drv_valid;
  int         hi_q[$];
  int         per_q[$];
  logic       prev_dout;
  int         hi_run, last_rise, first_rise, done_cycle, done_count;
  int         xfers, busy_low, busy_after, ready_late;

  function automatic logic o_dout();  return sel ? s_dout : m_dout; endfunction
  function automatic logic o_ready(); return sel ? s_byte_ready : m_byte_ready; endfunction
  function automatic logic o_busy();  return sel ? s_busy : m_busy; endfunction
  function automatic logic o_done();  return sel ? s_frame_done : m_frame_done; endfunction
  function automatic int   o_index(); return sel ? int'(s_byte_index) : int'(m_byte_index); endfunction
  function automatic logic [7:0] pat(input int i);
    case (i % 3)
      0: return 8'hFF;
      1: return 8'h00;
      default: return 8'hA5;
    endcase
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    logic [7:0] b;
    logic       v;
    logic       st;
    b  = (src_ptr < src_q.size()) ? src_q[src_ptr] : 8'h00;
    v  = (src_ptr < src_q.size()) && !(src_ptr == gap_idx && k < gap_release);
    st = 1'b0;
    foreach (start_k[i]) if (start_k[i] == k) st = 1'b1;
    drv_valid    = v;
    m_byte_in    = sel ? 8'h00 : b;
    m_byte_valid = sel ? 1'b0 : v;
    m_start      = sel ? 1'b0 : st;
    s_byte_in    = sel ? b : 8'h00;
    s_byte_valid = sel ? v : 1'b0;
    s_start      = sel ? st : 1'b0;
  endtask

  task automatic step();
    logic x;
    logic d;
    x = o_ready() && drv_valid;
    @(posedge clk);
    #1;
    k++;
    if (x) begin
      src_ptr++;
      xfers++;
    end
    d = o_dout();
    if (d && !prev_dout) begin
      if (last_rise >= 0) per_q.push_back(k - last_rise);
      else first_rise = k;
      last_rise = k;
      hi_run = 0;
    end
    if (d) hi_run++;
    if (!d && prev_dout) hi_q.push_back(hi_run);
    prev_dout = d;
    if (done_cycle < 0 && !o_busy()) busy_low++;
    else if (done_cycle >= 0 && o_busy()) busy_after++;
    if (o_done()) begin
      done_count++;
      if (done_cycle < 0) done_cycle = k;
    end
    if (xfers >= total_bytes && o_ready()) ready_late++;
    drive_inputs();
  endtask

  task automatic run_frame(input int limit, input int tail);
    hi_q.delete();
    per_q.delete();
    prev_dout = 1'b0; hi_run = 0; last_rise = -1; first_rise = -1;
    done_cycle = -1; done_count = 0; xfers = 0; busy_low = 0; busy_after = 0;
    ready_late = 0; src_ptr = 0; k = -1;
    drive_inputs();
    while (done_cycle < 0 && k < limit) step();
    repeat (tail) step();
  endtask

  task automatic build_exp();
    exp_q.delete();
    foreach (slot_bytes[i])
      for (int b = 7; b >= 0; b--) exp_q.push_back(slot_bytes[i][b] ? 8'd9 : 8'd4);
  endtask

  task automatic check_frame(input string tag, input int exp_done, input int odd_idx,
                             input int odd_val);
    check({tag, "_first_rise"}, first_rise, 2);
    check({tag, "_done_cycle"}, done_cycle, exp_done);
    check({tag, "_done_count"}, done_count, 1);
    check({tag, "_busy_low"}, busy_low, 0);
    check({tag, "_busy_after"}, busy_after, 0);
    check({tag, "_ready_late"}, ready_late, 0);
    check({tag, "_pulses"}, hi_q.size(), exp_q.size());
    for (int i = 0; i < hi_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_hi[%0d]", tag, i), hi_q[i], int'(exp_q[i]));
    check({tag, "_periods"}, per_q.size(), exp_q.size() - 1);
    for (int i = 0; i < per_q.size(); i++)
      check($sformatf("%s_per[%0d]", tag, i), per_q[i], (i == odd_idx) ? odd_val : 15);
    check({tag, "_byte_index"}, o_index(), total_bytes);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; gap_idx = -1; gap_release = 0; total_bytes = 24;
    k = -100; src_ptr = 0;
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", m_dout, 0);
    check("rst_busy", m_busy, 0);
    check("rst_byte_ready", m_byte_ready, 0);
    check("rst_frame_done", m_frame_done, 0);
    check("rst_byte_index", m_byte_index, 0);
    check("rst_underrun", m_underrun, 0);
    rst = 1'b0;

    // Frame A: pattern always valid, ignored starts mid-frame, in LATCH and on frame_done
    src_q.delete();
    for (int i = 0; i < 24; i++) src_q.push_back(pat(i));
    slot_bytes = src_q;
    build_exp();
    start_k = '{-1, 1000, 5000, 6481};
    run_frame(8000, 40);
    check_frame("a", 6481, -1, 0);
    check("a_underrun", m_underrun, 0);

    // Frame B: byte 5 withheld until cycle 683
    start_k = '{-1};
    gap_idx = 5; gap_release = 683;
    slot_bytes.delete();
`ifdef WS2812_UNDERRUN_FILL_EN
    for (int i = 0; i < 24; i++) slot_bytes.push_back(i < 5 ? pat(i) : (i == 5 ? 8'h00 : pat(i - 1)));
`else
    for (int i = 0; i < 24; i++) slot_bytes.push_back(pat(i));
`endif
    build_exp();
    run_frame(8000, 5);
`ifdef WS2812_UNDERRUN_FILL_EN
    check_frame("b", 6481, -1, 0);
    check("b_underrun", m_underrun, 1);
`else
    check_frame("b", 6564, 39, 98);
    check("b_underrun", m_underrun, 0);
`endif
    gap_idx = -1;

    // Frame C: reset during bit 3 of byte 10
    run_frame(1250, 0);
    check("c_pre_busy", m_busy, 1);
    rst = 1'b1;
    step();
    check("c_rst_dout", m_dout, 0);
    check("c_rst_busy", m_busy, 0);
    check("c_rst_byte_ready", m_byte_ready, 0);
    check("c_rst_byte_index", m_byte_index, 0);
    check("c_rst_frame_done", m_frame_done, 0);
    rst = 1'b0;

    // Frame D: fresh full frame after the abort
    slot_bytes = src_q;
    build_exp();
    run_frame(8000, 5);
    check_frame("d", 6481, -1, 0);

    // Frame E: RGBW, two LEDs, short latch; upstream keeps offering extra bytes
    sel = 1'b1;
    total_bytes = 8;
    src_q = '{8'h80, 8'h01, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h55, 8'hAA, 8'h12, 8'h34};
    slot_bytes = '{8'h80, 8'h01, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h55, 8'hAA};
    build_exp();
    run_frame(2000, 5);
    check_frame("e", 1011, -1, 0);
    check("e_transfers", xfers, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ws2812_strip_driver.md
Name: ws2812_strip_driver

Overview:
Parametrised successor to the single-byte WS2812 output shifter. It serialises a full frame of NUM_LEDS × BYTES_PER_LED bytes onto one WS2812/SK6812 data line, supporting both RGB and RGBW. Bytes are pulled from an upstream source (fader plus gamma stage) through a ready/valid handshake with a one-byte holding register. After the last bit it drives the latch/reset gap and then reports frame completion.

Parameters:
NUM_LEDS, 8, LEDs per frame (≥1)
BYTES_PER_LED, 3, 3 = RGB, 4 = RGBW
TBIT, 15, clock cycles per bit slot (1.25 us at 12 MHz)
T0H, 4, high cycles for a 0 bit (0 < T0H < T1H)
T1H, 9, high cycles for a 1 bit (T1H < TBIT)
TLATCH, 3600, low cycles of the latch gap after a frame (300 us at 12 MHz)

Ports:
CLK  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle frame request; ignored unless idle
byte_in  in  8  next colour byte, post-gamma
byte_valid  in  1  byte_in valid
byte_ready  out  1  holding register empty and frame still needs bytes
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse at end of latch gap
dout  out  1  WS2812 data line
byte_index  out  clog2(NUM_LEDS*BYTES_PER_LED+1)  count of bytes accepted in the current frame
underrun  out  1  sticky flag, only meaningful with the optional feature

Behaviour:
- Reset: state IDLE; dout=0, busy=0, byte_ready=0, frame_done=0, byte_index=0, underrun=0; holding register empty. Reset mid-frame aborts on the next edge with dout=0. No partial latch gap is generated.
- TOTAL = NUM_LEDS*BYTES_PER_LED. A byte transfers on a rising edge where byte_ready && byte_valid. byte_index increments on each transfer and saturates at TOTAL.
- byte_ready = busy && holding register empty && byte_index < TOTAL. It is registered and updates the cycle after the register empties or fills.
- States: IDLE → WAIT → BIT → (BIT | WAIT | LATCH) → IDLE.
- IDLE: dout=0. When start=1, go to WAIT, set busy=1, clear byte_index, clear the holding register.
- WAIT: dout=0. When the holding register is full, move it into the 8-bit shift register, mark the holding register empty, and enter BIT. The first high cycle of dout comes on the edge after the load.
- BIT: the bit counter runs 0..TBIT-1. dout=1 while the counter is below THIGH, where THIGH = T1H if the current MSB is 1, else T0H; otherwise dout=0. Shifting is MSB first.
- When the counter reaches TBIT-1 on bit 7:
  - if more bytes remain and the holding register is full, load it and continue BIT seamlessly with no gap cycle;
  - if more bytes remain and the holding register is empty, underrun: go to WAIT with dout=0 (stall; the strip may latch early);
  - if the last byte is done, go to LATCH.
- Byte boundaries are therefore seamless as long as upstream refills the register within 8*TBIT cycles.
- LATCH: dout=0 for exactly TLATCH cycles. Then frame_done=1 for one cycle, busy=0, and return to IDLE.
- start while busy (including during LATCH) is ignored; there is no queuing.
- start and the frame_done cycle coinciding: start is ignored, because busy is still high in that cycle.
- byte_valid without byte_ready is ignored.
- Frame length in cycles with no stalls = 1 (load) + TOTAL*8*TBIT + TLATCH, counted from start to frame_done.

Optional Feature:
WS2812_UNDERRUN_FILL_EN
- Defined: at a byte boundary with an empty holding register, the driver sends 0x00 in place of the missing byte, without stalling, and sets underrun=1. underrun is sticky until rst or the next accepted start. byte_index still counts only real transfers, and a late byte is still accepted for the following slot. The frame always ends after exactly TOTAL byte slots.
- Undefined: the WAIT stall behaviour above applies; underrun is tied to 0.

Test Plan:
- Defaults, start, bytes 0xFF,0x00,0xA5 ×8 always valid → 192 bit slots; 0xFF slots give 9 high + 6 low cycles, 0x00 slots give 4 high + 11 low; 0xA5 high times read 9,4,9,4,4,9,4,9; frame_done exactly 1+2880+3600 cycles after start.
- Byte stream with byte_valid dropped for 200 cycles at byte 5 (macro off) → dout low from the end of byte 4 until the refill, then byte 5 continues; busy stays high; byte_index reaches 24.
- Same stimulus with the macro on → byte 5 slot is sent as eight 4-high pulses, underrun=1, byte_index ends at 24, frame_done at the nominal cycle count.
- start pulsed mid-frame and again during LATCH → no effect; exactly one frame_done pulse.
- rst asserted during bit 3 of byte 10 → the next edge gives dout=0, busy=0, byte_ready=0, byte_index=0; a fresh start produces a full, correct frame.
- NUM_LEDS=2, BYTES_PER_LED=4, TLATCH=50 → exactly 8 transfers, 64 bit slots, byte_ready never high after the 8th transfer.
